cfg_axilite: RTL and testbench

//  AXI4-Lite slave that bridges processor register writes onto the cfg bus (cfg_addr/cfg_data/cfg_valid)

---
 rtl/cfg_axilite_pkg.sv | 26 ++
 rtl/cfg_axilite_if.sv | 40 ++++
 rtl/cfg_shadow_regs.sv | 41 ++++
 rtl/cfg_axilite.sv | 179 +++++++++++++++++
 tb/tb_cfg_axilite.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_axilite_pkg.sv
// Shared constants and helpers for the AXI4-Lite to cfg-bus bridge.
package cfg_axilite_pkg;

    localparam int unsigned AXIL_DWIDTH = 32;
    localparam int unsigned AXIL_SWIDTH = AXIL_DWIDTH / 8;
    localparam int unsigned RESP_WIDTH  = 2;

    localparam logic [RESP_WIDTH-1:0] RESP_OKAY = 2'b00;

    // Replace the bytes of i_old selected by i_strb with the matching bytes of i_new.
    function automatic logic [AXIL_DWIDTH-1:0] byte_merge(
        input logic [AXIL_DWIDTH-1:0] i_old,
        input logic [AXIL_DWIDTH-1:0] i_new,
        input logic [AXIL_SWIDTH-1:0] i_strb
    );
        logic [AXIL_DWIDTH-1:0] v_res;
        v_res = i_old;
        for (int unsigned b = 0; b < AXIL_SWIDTH; b++) begin
            if (i_strb[b]) begin
                v_res[8*b +: 8] = i_new[8*b +: 8];
            end
        end
        return v_res;
    endfunction

endpackage

// File: rtl/cfg_axilite_if.sv
// AXI4-Lite bus bundle between a processor-side master and the cfg bridge.
interface cfg_axilite_if
    import cfg_axilite_pkg::*;
#(
    parameter int unsigned AWIDTH = 32
);

    logic [AWIDTH-1:0]      axi_awaddr;
    logic                   axi_awvalid;
    logic                   axi_awready;
    logic [AXIL_DWIDTH-1:0] axi_wdata;
    logic [AXIL_SWIDTH-1:0] axi_wstrb;
    logic                   axi_wvalid;
    logic                   axi_wready;
    logic [RESP_WIDTH-1:0]  axi_bresp;
    logic                   axi_bvalid;
    logic                   axi_bready;
    logic [AWIDTH-1:0]      axi_araddr;
    logic                   axi_arvalid;
    logic                   axi_arready;
    logic [AXIL_DWIDTH-1:0] axi_rdata;
    logic [RESP_WIDTH-1:0]  axi_rresp;
    logic                   axi_rvalid;
    logic                   axi_rready;

    modport master (
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
               axi_araddr, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport slave (
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
               axi_araddr, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

endinterface

// File: rtl/cfg_shadow_regs.sv
// Shadow register file: one byte-enabled write port, two asynchronous read ports.
module cfg_shadow_regs
    import cfg_axilite_pkg::*;
#(
    parameter int unsigned AWIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic [AWIDTH-1:0]      i_waddr,
    input  logic [AXIL_DWIDTH-1:0] i_wdata,
    input  logic [AXIL_SWIDTH-1:0] i_wstrb,
    input  logic [AWIDTH-1:0]      i_raddr_a,
    output logic [AXIL_DWIDTH-1:0] o_rdata_a_c,
    input  logic [AWIDTH-1:0]      i_raddr_b,
    output logic [AXIL_DWIDTH-1:0] o_rdata_b_c
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;

    logic [AXIL_DWIDTH-1:0] r_mem [DEPTH];

    // Storage: cleared on reset, byte lanes updated under strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int unsigned b = 0; b < AXIL_SWIDTH; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata_a_c = r_mem[i_raddr_a];
    assign o_rdata_b_c = r_mem[i_raddr_b];

endmodule

// File: rtl/cfg_axilite.sv
// AXI4-Lite slave that turns each completed write into a one-cycle cfg-bus strobe
// and serves reads from a shadow copy of the last value written per cfg address.
module cfg_axilite
    import cfg_axilite_pkg::*;
#(
    parameter int unsigned AXIL_AWIDTH = 32,
    parameter int unsigned CFG_AWIDTH  = 5,
    parameter int unsigned CFG_DWIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    cfg_axilite_if.slave          axi,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic                  cfg_valid
);

    // Write-channel state
    logic                   r_aw_hold;
    logic                   r_w_hold;
    logic [CFG_AWIDTH-1:0]  r_aw_idx;
    logic [AXIL_DWIDTH-1:0] r_wdata;
    logic [AXIL_SWIDTH-1:0] r_wstrb;
    logic                   r_awready;
    logic                   r_wready;
    logic                   r_bvalid;
    logic                   r_cfg_valid;
    logic [CFG_AWIDTH-1:0]  r_cfg_addr;
    logic [CFG_DWIDTH-1:0]  r_cfg_data;

    // Read-channel state
    logic                   r_arready;
    logic                   r_rvalid;
    logic [AXIL_DWIDTH-1:0] r_rdata;

    // Combinational helpers
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_fire;
    logic [CFG_AWIDTH-1:0]  w_aw_idx;
    logic [CFG_AWIDTH-1:0]  w_ar_idx;
    logic [CFG_AWIDTH-1:0]  w_wr_idx;
    logic [AXIL_DWIDTH-1:0] w_wr_data;
    logic [AXIL_SWIDTH-1:0] w_wr_strb;
    logic [AXIL_DWIDTH-1:0] w_wr_old;
    logic [AXIL_DWIDTH-1:0] w_rd_data;
    logic [AXIL_DWIDTH-1:0] w_merged;
    logic                   w_unused_addr;

    // Next-state values
    logic                   w_aw_hold_n;
    logic                   w_w_hold_n;
    logic                   w_bvalid_n;
    logic                   w_rvalid_n;

    assign w_aw_idx = axi.axi_awaddr[CFG_AWIDTH+1:2];
    assign w_ar_idx = axi.axi_araddr[CFG_AWIDTH+1:2];

    // Upper and sub-word address bits are deliberately ignored (aliasing is allowed).
    assign w_unused_addr = ^{axi.axi_awaddr[AXIL_AWIDTH-1:CFG_AWIDTH+2], axi.axi_awaddr[1:0],
                             axi.axi_araddr[AXIL_AWIDTH-1:CFG_AWIDTH+2], axi.axi_araddr[1:0]};

    assign w_aw_hs = axi.axi_awvalid & r_awready;
    assign w_w_hs  = axi.axi_wvalid  & r_wready;
    assign w_ar_hs = axi.axi_arvalid & r_arready;
    assign w_fire  = (r_aw_hold | w_aw_hs) & (r_w_hold | w_w_hs);

    // A held beat takes priority; otherwise the beat handshaking this cycle is used.
    assign w_wr_idx  = r_aw_hold ? r_aw_idx : w_aw_idx;
    assign w_wr_data = r_w_hold  ? r_wdata  : axi.axi_wdata;
    assign w_wr_strb = r_w_hold  ? r_wstrb  : axi.axi_wstrb;
    assign w_merged  = byte_merge(w_wr_old, w_wr_data, w_wr_strb);

    cfg_shadow_regs #(
        .AWIDTH (CFG_AWIDTH)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .i_we        (w_fire),
        .i_waddr     (w_wr_idx),
        .i_wdata     (w_wr_data),
        .i_wstrb     (w_wr_strb),
        .i_raddr_a   (w_wr_idx),
        .o_rdata_a_c (w_wr_old),
        .i_raddr_b   (w_ar_idx),
        .o_rdata_b_c (w_rd_data)
    );

    // Next-state for holds and response valids.
    always_comb begin
        w_aw_hold_n = r_aw_hold;
        w_w_hold_n  = r_w_hold;
        w_bvalid_n  = r_bvalid;
        w_rvalid_n  = r_rvalid;

        if (w_fire) begin
            w_aw_hold_n = 1'b0;
            w_w_hold_n  = 1'b0;
            w_bvalid_n  = 1'b1;
        end else begin
            w_aw_hold_n = r_aw_hold | w_aw_hs;
            w_w_hold_n  = r_w_hold  | w_w_hs;
            if (r_bvalid && axi.axi_bready) begin
                w_bvalid_n = 1'b0;
            end
        end

        if (w_ar_hs) begin
            w_rvalid_n = 1'b1;
        end else if (r_rvalid && axi.axi_rready) begin
            w_rvalid_n = 1'b0;
        end
    end

    // Write channel registers and cfg-bus strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_hold   <= 1'b0;
            r_w_hold    <= 1'b0;
            r_aw_idx    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_bvalid    <= 1'b0;
            r_awready   <= 1'b1;
            r_wready    <= 1'b1;
            r_cfg_valid <= 1'b0;
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
        end else begin
            r_aw_hold   <= w_aw_hold_n;
            r_w_hold    <= w_w_hold_n;
            r_bvalid    <= w_bvalid_n;
            r_awready   <= ~w_aw_hold_n & ~w_bvalid_n;
            r_wready    <= ~w_w_hold_n  & ~w_bvalid_n;
            r_cfg_valid <= w_fire;
            if (w_aw_hs) begin
                r_aw_idx <= w_aw_idx;
            end
            if (w_w_hs) begin
                r_wdata <= axi.axi_wdata;
                r_wstrb <= axi.axi_wstrb;
            end
            if (w_fire) begin
                r_cfg_addr <= w_wr_idx;
                r_cfg_data <= CFG_DWIDTH'(w_merged);
            end
        end
    end

    // Read channel registers: capture shadow on address handshake, hold until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rdata   <= '0;
        end else begin
            r_rvalid  <= w_rvalid_n;
            r_arready <= ~w_rvalid_n;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
            end
        end
    end

    assign axi.axi_awready = r_awready;
    assign axi.axi_wready  = r_wready;
    assign axi.axi_bvalid  = r_bvalid;
    assign axi.axi_bresp   = RESP_OKAY;
    assign axi.axi_arready = r_arready;
    assign axi.axi_rvalid  = r_rvalid;
    assign axi.axi_rdata   = r_rdata;
    assign axi.axi_rresp   = RESP_OKAY;

    assign cfg_valid = r_cfg_valid;
    assign cfg_addr  = r_cfg_addr;
    assign cfg_data  = r_cfg_data;

endmodule

// File: tb/tb_cfg_axilite.sv
// Bench for cfg_axilite: directed scenarios plus randomized writes/reads against a shadow model.
module tb_cfg_axilite;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] shadow_m [32];

    cfg_axilite_if #(.AWIDTH(32)) axi ();

    cfg_axilite #(
        .AXIL_AWIDTH (32),
        .CFG_AWIDTH  (5),
        .CFG_DWIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (axi),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Reference merge: mask arithmetic over the four byte lanes.
    function automatic logic [31:0] model_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic int model_idx(input logic [31:0] addr);
        return int'((addr >> 2) % 32);
    endfunction

    task automatic idle();
        axi.axi_awvalid = 1'b0;
        axi.axi_wvalid  = 1'b0;
        axi.axi_arvalid = 1'b0;
        axi.axi_bready  = 1'b1;
        axi.axi_rready  = 1'b1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) shadow_m[i] = 32'h0;
    endtask

    // Drive AW and W together; return the cfg pulse contents seen, bounded wait.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [4:0] got_a, output logic [31:0] got_d, output bit seen);
        axi.axi_awaddr  = addr;
        axi.axi_awvalid = 1'b1;
        axi.axi_wdata   = data;
        axi.axi_wstrb   = strb;
        axi.axi_wvalid  = 1'b1;
        seen  = 1'b0;
        got_a = '0;
        got_d = '0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (cfg_valid === 1'b1) begin
                seen  = 1'b1;
                got_a = cfg_addr;
                got_d = cfg_data;
            end
        end
        axi.axi_awvalid = 1'b0;
        axi.axi_wvalid  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output bit seen);
        axi.axi_araddr  = addr;
        axi.axi_arvalid = 1'b1;
        seen = 1'b0;
        data = '0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (axi.axi_rvalid === 1'b1) begin
                seen = 1'b1;
                data = axi.axi_rdata;
            end
        end
        axi.axi_arvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] got;
        got = {axi.axi_awready, axi.axi_wready, axi.axi_arready, axi.axi_bvalid,
               axi.axi_rvalid, cfg_valid, (cfg_addr != 0), (cfg_data != 0)};
        total++;
        if (got !== 8'b1110_0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected %b", got, 8'b1110_0000);
        end
    endtask

    task automatic test_same_cycle();
        axi.axi_bready  = 1'b0;
        axi.axi_awaddr  = 32'h0000_000C;
        axi.axi_awvalid = 1'b1;
        axi.axi_wdata   = 32'hDEAD_BEEF;
        axi.axi_wstrb   = 4'hF;
        axi.axi_wvalid  = 1'b1;
        @(negedge clk);
        axi.axi_awvalid = 1'b0;
        axi.axi_wvalid  = 1'b0;
        shadow_m[3] = 32'hDEAD_BEEF;
        total++;
        if ({cfg_valid, axi.axi_bvalid, axi.axi_bresp} !== 4'b1100 || cfg_addr !== 5'd3
            || cfg_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL same_cycle: valid=%b bvalid=%b bresp=%b addr=%0d data=%h expected 1 1 00 3 deadbeef",
                     cfg_valid, axi.axi_bvalid, axi.axi_bresp, cfg_addr, cfg_data);
        end
        @(negedge clk);
        total++;
        if (cfg_valid !== 1'b0 || axi.axi_bvalid !== 1'b1 || cfg_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL pulse_width: valid=%b bvalid=%b data=%h expected 0 1 deadbeef",
                     cfg_valid, axi.axi_bvalid, cfg_data);
        end
        axi.axi_bready = 1'b1;
        @(negedge clk);
        total++;
        if ({axi.axi_bvalid, axi.axi_awready, axi.axi_wready} !== 3'b011) begin
            bad++;
            $display("FAIL bresp_release: bvalid/awready/wready=%b expected 011",
                     {axi.axi_bvalid, axi.axi_awready, axi.axi_wready});
        end
    endtask

    task automatic test_split();
        bit seen;
        axi.axi_wdata  = 32'h1122_3344;
        axi.axi_wstrb  = 4'hF;
        axi.axi_wvalid = 1'b1;
        @(negedge clk);
        axi.axi_wvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            total++;
            if ({axi.axi_awready, axi.axi_wready, cfg_valid} !== 3'b100) begin
                bad++;
                $display("FAIL split_wait c%0d: awready/wready/cfg_valid=%b expected 100", c,
                         {axi.axi_awready, axi.axi_wready, cfg_valid});
            end
            if (c < 3) @(negedge clk);
        end
        axi.axi_awaddr  = 32'h0000_0004;
        axi.axi_awvalid = 1'b1;
        @(negedge clk);
        axi.axi_awvalid = 1'b0;
        seen = cfg_valid;
        shadow_m[1] = 32'h1122_3344;
        total++;
        if (seen !== 1'b1 || cfg_addr !== 5'd1 || cfg_data !== 32'h1122_3344) begin
            bad++;
            $display("FAIL split_fire: valid=%b addr=%0d data=%h expected 1 1 11223344", seen, cfg_addr, cfg_data);
        end
        @(negedge clk);
    endtask

    task automatic test_strobe_merge();
        logic [4:0]  ga;
        logic [31:0] gd;
        bit          seen;
        do_write(32'h0000_0008, 32'hAABB_CCDD, 4'hF, ga, gd, seen);
        shadow_m[2] = 32'hAABB_CCDD;
        do_write(32'h0000_0008, 32'h0000_0055, 4'b0001, ga, gd, seen);
        shadow_m[2] = model_merge(shadow_m[2], 32'h0000_0055, 4'b0001);
        total++;
        if (!seen || ga !== 5'd2 || gd !== 32'hAABB_CC55) begin
            bad++;
            $display("FAIL strobe_merge: seen=%0b addr=%0d data=%h expected 1 2 aabbcc55", seen, ga, gd);
        end
        do_read(32'h0000_0008, gd, seen);
        total++;
        if (!seen || gd !== 32'hAABB_CC55) begin
            bad++;
            $display("FAIL strobe_read: seen=%0b rdata=%h expected aabbcc55", seen, gd);
        end
        do_write(32'h0000_0008, 32'hFFFF_FFFF, 4'b0000, ga, gd, seen);
        total++;
        if (!seen || gd !== 32'hAABB_CC55) begin
            bad++;
            $display("FAIL zero_strobe: seen=%0b data=%h expected pulse with aabbcc55", seen, gd);
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        axi.axi_bready  = 1'b0;
        axi.axi_awaddr  = 32'h0000_0020;
        axi.axi_wdata   = 32'h0BAD_F00D;
        axi.axi_wstrb   = 4'hF;
        axi.axi_awvalid = 1'b1;
        axi.axi_wvalid  = 1'b1;
        @(negedge clk);
        total++;
        if (cfg_valid !== 1'b1 || cfg_addr !== 5'd8) begin
            bad++;
            $display("FAIL bp_first: valid=%b addr=%0d expected 1 8", cfg_valid, cfg_addr);
        end
        shadow_m[8] = 32'h0BAD_F00D;
        axi.axi_awaddr = 32'h0000_0024;
        axi.axi_wdata  = 32'h5555_AAAA;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({axi.axi_bvalid, axi.axi_awready, axi.axi_wready, cfg_valid} !== 4'b1000) begin
                bad++;
                $display("FAIL bp_stall c%0d: bvalid/awready/wready/cfg_valid=%b expected 1000", c,
                         {axi.axi_bvalid, axi.axi_awready, axi.axi_wready, cfg_valid});
            end
        end
        axi.axi_bready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (cfg_valid === 1'b1) seen = 1'b1;
        end
        axi.axi_awvalid = 1'b0;
        axi.axi_wvalid  = 1'b0;
        shadow_m[9] = 32'h5555_AAAA;
        total++;
        if (!seen || cfg_addr !== 5'd9 || cfg_data !== 32'h5555_AAAA) begin
            bad++;
            $display("FAIL bp_second: seen=%0b addr=%0d data=%h expected 1 9 5555aaaa", seen, cfg_addr, cfg_data);
        end
        @(negedge clk);
    endtask

    task automatic test_rw_collision();
        logic [4:0]  ga;
        logic [31:0] gd;
        bit          seen;
        do_write(32'h0000_0010, 32'h1, 4'hF, ga, gd, seen);
        shadow_m[4] = 32'h1;
        axi.axi_rready  = 1'b0;
        axi.axi_awaddr  = 32'h0000_0010;
        axi.axi_wdata   = 32'h2;
        axi.axi_wstrb   = 4'hF;
        axi.axi_araddr  = 32'h0000_0010;
        axi.axi_awvalid = 1'b1;
        axi.axi_wvalid  = 1'b1;
        axi.axi_arvalid = 1'b1;
        @(negedge clk);
        axi.axi_awvalid = 1'b0;
        axi.axi_wvalid  = 1'b0;
        axi.axi_arvalid = 1'b0;
        shadow_m[4] = 32'h2;
        total++;
        if (cfg_valid !== 1'b1 || cfg_data !== 32'h2 || axi.axi_rvalid !== 1'b1 || axi.axi_rdata !== 32'h1) begin
            bad++;
            $display("FAIL rw_collision: cfg_valid=%b cfg_data=%h rvalid=%b rdata=%h expected 1 2 1 1",
                     cfg_valid, cfg_data, axi.axi_rvalid, axi.axi_rdata);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (axi.axi_rvalid !== 1'b1 || axi.axi_rdata !== 32'h1 || axi.axi_arready !== 1'b0) begin
                bad++;
                $display("FAIL rvalid_hold c%0d: rvalid=%b rdata=%h arready=%b expected 1 1 0", c,
                         axi.axi_rvalid, axi.axi_rdata, axi.axi_arready);
            end
        end
        axi.axi_rready = 1'b1;
        @(negedge clk);
        total++;
        if (axi.axi_rvalid !== 1'b0 || axi.axi_arready !== 1'b1) begin
            bad++;
            $display("FAIL rvalid_release: rvalid=%b arready=%b expected 0 1", axi.axi_rvalid, axi.axi_arready);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, data, exp_d;
        logic [3:0]  strb;
        logic [4:0]  ga;
        logic [31:0] gd;
        bit          seen, aw_first;
        int          skew, idx;
        for (int it = 0; it < 40; it++) begin
            addr     = $urandom;
            data     = $urandom;
            strb     = 4'($urandom_range(0, 15));
            skew     = $urandom_range(0, 3);
            aw_first = 1'($urandom_range(0, 1));
            idx      = model_idx(addr);
            exp_d    = model_merge(shadow_m[idx], data, strb);
            shadow_m[idx] = exp_d;
            if (skew == 0) begin
                do_write(addr, data, strb, ga, gd, seen);
            end else begin
                axi.axi_awaddr = addr;
                axi.axi_wdata  = data;
                axi.axi_wstrb  = strb;
                if (aw_first) axi.axi_awvalid = 1'b1;
                else          axi.axi_wvalid  = 1'b1;
                @(negedge clk);
                axi.axi_awvalid = 1'b0;
                axi.axi_wvalid  = 1'b0;
                total++;
                if (cfg_valid !== 1'b0 || axi.axi_awready !== !aw_first || axi.axi_wready !== aw_first) begin
                    bad++;
                    $display("FAIL rand_half it%0d: cfg_valid=%b awready=%b wready=%b aw_first=%0b",
                             it, cfg_valid, axi.axi_awready, axi.axi_wready, aw_first);
                end
                repeat (skew - 1) @(negedge clk);
                if (aw_first) axi.axi_wvalid  = 1'b1;
                else          axi.axi_awvalid = 1'b1;
                @(negedge clk);
                axi.axi_awvalid = 1'b0;
                axi.axi_wvalid  = 1'b0;
                seen = cfg_valid;
                ga   = cfg_addr;
                gd   = cfg_data;
                @(negedge clk);
            end
            total++;
            if (seen !== 1'b1 || ga !== 5'(idx) || gd !== exp_d) begin
                bad++;
                $display("FAIL rand_write it%0d: seen=%0b addr=%0d data=%h expected 1 %0d %h",
                         it, seen, ga, gd, idx, exp_d);
            end
            addr = $urandom;
            do_read(addr, gd, seen);
            total++;
            if (!seen || gd !== shadow_m[model_idx(addr)]) begin
                bad++;
                $display("FAIL rand_read it%0d: seen=%0b rdata=%h expected %h",
                         it, seen, gd, shadow_m[model_idx(addr)]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0]  ga;
        logic [31:0] gd;
        bit          seen;
        // Reset with bvalid, rvalid and cfg_valid all high.
        axi.axi_bready  = 1'b0;
        axi.axi_rready  = 1'b0;
        axi.axi_awaddr  = 32'h0000_0014;
        axi.axi_wdata   = 32'h7777_7777;
        axi.axi_wstrb   = 4'hF;
        axi.axi_araddr  = 32'h0000_000C;
        axi.axi_awvalid = 1'b1;
        axi.axi_wvalid  = 1'b1;
        axi.axi_arvalid = 1'b1;
        @(negedge clk);
        idle();
        axi.axi_bready = 1'b0;
        axi.axi_rready = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if ({axi.axi_bvalid, axi.axi_rvalid, cfg_valid, axi.axi_awready, axi.axi_wready, axi.axi_arready}
            !== 6'b000111) begin
            bad++;
            $display("FAIL async_reset: bvalid/rvalid/cfg_valid/awready/wready/arready=%b expected 000111",
                     {axi.axi_bvalid, axi.axi_rvalid, cfg_valid, axi.axi_awready, axi.axi_wready, axi.axi_arready});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        idle();
        // Reset with only an address beat held.
        axi.axi_awaddr  = 32'h0000_0008;
        axi.axi_awvalid = 1'b1;
        @(negedge clk);
        axi.axi_awvalid = 1'b0;
        total++;
        if (axi.axi_awready !== 1'b0) begin
            bad++;
            $display("FAIL aw_held: awready=%b expected 0", axi.axi_awready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        axi.axi_wdata  = 32'hCAFE_0000;
        axi.axi_wstrb  = 4'hF;
        axi.axi_wvalid = 1'b1;
        @(negedge clk);
        axi.axi_wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (cfg_valid !== 1'b0 || axi.axi_awready !== 1'b1 || axi.axi_wready !== 1'b0) begin
                bad++;
                $display("FAIL hold_dropped c%0d: cfg_valid=%b awready=%b wready=%b expected 0 1 0",
                         c, cfg_valid, axi.axi_awready, axi.axi_wready);
            end
            @(negedge clk);
        end
        axi.axi_awaddr  = 32'h0000_0018;
        axi.axi_awvalid = 1'b1;
        @(negedge clk);
        axi.axi_awvalid = 1'b0;
        shadow_m[6] = 32'hCAFE_0000;
        total++;
        if (cfg_valid !== 1'b1 || cfg_addr !== 5'd6 || cfg_data !== 32'hCAFE_0000) begin
            bad++;
            $display("FAIL post_reset_write: valid=%b addr=%0d data=%h expected 1 6 cafe0000",
                     cfg_valid, cfg_addr, cfg_data);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = (i == 0) ? 32'h0000_000C : (i == 1) ? 32'h0000_0014 : 32'h0000_0008;
            do_read(a, gd, seen);
            total++;
            if (!seen || gd !== shadow_m[model_idx(a)]) begin
                bad++;
                $display("FAIL shadow_cleared a=%h: seen=%0b rdata=%h expected %h", a, seen, gd, shadow_m[model_idx(a)]);
            end
        end
        do_write(32'h0000_0018, 32'h0000_0000, 4'b0000, ga, gd, seen);
        total++;
        if (!seen || gd !== 32'hCAFE_0000) begin
            bad++;
            $display("FAIL post_reset_shadow: seen=%0b data=%h expected cafe0000", seen, gd);
        end
    endtask

    initial begin
        rst = 1'b1;
        axi.axi_awaddr = '0;
        axi.axi_wdata  = '0;
        axi.axi_wstrb  = '0;
        axi.axi_araddr = '0;
        idle();
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_same_cycle();
        test_split();
        test_strobe_merge();
        test_backpressure();
        test_rw_collision();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
